stream_demux_1xn: RTL and testbench
===================================

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter N_OUT, default 4, number of output channels (2..16).
REQ-002 Parameter DATA_W, default 8, payload width in bits (1..64).
REQ-003 Parameter DROP_MODE, default 0, 0 = backpressure when the target is busy, 1 = discard when the target is busy.
REQ-004 Parameter CNT_W, default 16, width of the drop and error counters.
REQ-005 Port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 Port rst_n  in  1  reset, synchronous and active-low.
REQ-007 Port i_valid  in  1  input beat present.
REQ-008 Port i_data  in  DATA_W  input payload.
REQ-009 Port i_sel  in  SEL_W = max(1, clog2(N_OUT))  destination channel index.
REQ-010 Port i_ready  out  1  input beat accepted this cycle when high together with i_valid.
REQ-011 Port y_valid  out  N_OUT  per-channel output valid.
REQ-012 Port y_data  out  N_OUT*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 Port y_ready  in  N_OUT  per-channel downstream ready.
REQ-014 Port drop_cnt  out  CNT_W  beats discarded because the target was busy (DROP_MODE=1 only).
REQ-015 Port err_cnt  out  CNT_W  beats discarded because of an out-of-range i_sel.
REQ-016 Port err_flag  out  1  sticky flag, set on the first out-of-range beat.

Function
REQ-017 Each channel k has one output slot (valid bit plus DATA_W register); y_valid[k] and y_data[k] are driven directly from the slot registers.
REQ-018 Slot k is free when it is empty, or when y_valid[k] and y_ready[k] are both high in the same cycle.
REQ-019 DROP_MODE=0: i_ready is high exactly when i_sel < N_OUT and slot[i_sel] is free, or when i_sel >= N_OUT.
REQ-020 DROP_MODE=1: i_ready is constantly 1 outside reset.
REQ-021 i_ready is combinational from i_sel, slot state and y_ready, with no path from i_valid.
REQ-022 An accepted beat (i_valid && i_ready) with i_sel < N_OUT and a free target slot loads that slot at the next edge, so latency is exactly 1 cycle.
REQ-023 An accepted beat with i_sel < N_OUT and a busy target slot (DROP_MODE=1 only) is discarded, the slot is left unchanged and drop_cnt increments by 1.
REQ-024 An accepted beat with i_sel >= N_OUT is discarded in both modes, err_cnt increments by 1 and err_flag sets.
REQ-025 Simultaneous unload and load on the same slot keeps y_valid[k] high and replaces y_data[k] with the new beat, sustaining full throughput of 1 beat per cycle per channel.
REQ-026 A slot that unloads with no new load clears y_valid[k] at the next edge; y_data[k] holds its last value.
REQ-027 A slot holding data keeps it stable while y_ready[k] is low; there is no overwrite in either mode.
REQ-028 Channels operate independently; a stalled channel does not block beats to other channels.
REQ-029 drop_cnt and err_cnt saturate at 2^CNT_W-1 and do not wrap.
REQ-030 err_flag clears only on reset.
REQ-031 Beats are never duplicated; per-channel order equals input order.

Reset
REQ-032 While rst_n is sampled low: y_valid = 0, y_data = 0, drop_cnt = 0, err_cnt = 0, err_flag = 0, and i_ready is forced to 0.
REQ-033 Reset mid-operation discards all slot contents at that edge without emitting any beat.
REQ-034 The first beat can be accepted in the first cycle with rst_n high.

Structure
REQ-035 Package stream_demux_pkg holds the default parameter values, the SEL_W computation function and the saturating-increment function.
REQ-036 One sub-module demux_out_slot (valid/data register, load, unload) is instantiated N_OUT times in a generate loop.
REQ-037 The top level contains the select decode, the ready mux and the counters only.

Verification
REQ-038 Bench shall cover: N_OUT=4, DROP_MODE=0, all y_ready=1, beats 0xA1..0xA4 with i_sel 0..3 on consecutive cycles -> each appears on y_data[k] one cycle later, i_ready stays 1 throughout.
REQ-039 Bench shall cover: y_ready[2]=0, two beats to channel 2 (0x55 then 0x66) -> 0x55 held, i_ready=0 for the second beat until y_ready[2]=1, then 0x66 follows, with no loss.
REQ-040 Bench shall cover: DROP_MODE=1, y_ready[1]=0, three beats to channel 1 -> first beat held, drop_cnt=2, i_ready constantly 1.
REQ-041 Bench shall cover: N_OUT=3, i_sel=3 with i_valid=1 -> i_ready=1, no y_valid rises, err_cnt=1, err_flag=1 and stays set.
REQ-042 Bench shall cover: CNT_W=2, DROP_MODE=1, five drops -> drop_cnt stops at 3.
REQ-043 Bench shall cover: rst_n low for one cycle while slots 0 and 3 are full -> the next cycle shows y_valid=0000 and all counters 0, and the first post-reset beat is delivered normally.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared defaults and helper functions for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

    localparam int DEF_N_OUT     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DROP_MODE = 0;
    localparam int DEF_CNT_W     = 16;

    // Select width is clog2 of the channel count, but never narrower than one bit.
    function automatic int sel_width(input int n_out);
        return (n_out < 2) ? 1 : $clog2(n_out);
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = {64{1'b1}} >> (64 - width);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output slot of the demultiplexer: a valid bit plus a payload register.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign free = !valid || ready;

    // Load wins over unload so back-to-back beats keep valid high; data holds after unload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1xn.sv
// 1-to-N stream demultiplexer: routes each input beat to the slot chosen by i_sel,
// with either backpressure or discard when the target slot is occupied.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int N_OUT     = DEF_N_OUT,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DROP_MODE = DEF_DROP_MODE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic [DATA_W-1:0]           i_data,
    input  logic [sel_width(N_OUT)-1:0] i_sel,
    output logic                        i_ready,
    output logic [N_OUT-1:0]            y_valid,
    output logic [N_OUT*DATA_W-1:0]     y_data,
    input  logic [N_OUT-1:0]            y_ready,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic [CNT_W-1:0]            err_cnt,
    output logic                        err_flag
);

    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] load_vec;
    logic             sel_in_range;
    logic             target_free;
    logic             accept;
    logic             drop_event;
    logic             err_event;

    assign sel_in_range = (int'(i_sel) < N_OUT);

    // i_ready depends only on select, slot state and downstream ready, never on i_valid.
    assign i_ready = rst_n && ((DROP_MODE != 0) || !sel_in_range || target_free);

    assign accept     = i_valid && i_ready;
    assign drop_event = accept && sel_in_range && !target_free;
    assign err_event  = accept && !sel_in_range;

    // Decode the select into the target's free status and a one-hot load strobe.
    always_comb begin
        target_free = 1'b0;
        load_vec    = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(i_sel) == k) begin
                target_free = slot_free[k];
                load_vec[k] = accept && slot_free[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : gen_slot
            demux_out_slot #(
                .DATA_W(DATA_W)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load_vec[g]),
                .load_data(i_data),
                .ready    (y_ready[g]),
                .valid    (y_valid[g]),
                .data     (y_data[g*DATA_W +: DATA_W]),
                .free     (slot_free[g])
            );
        end
    endgenerate

    // Saturating drop/error counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if (drop_event) begin
                drop_cnt <= CNT_W'(sat_inc(64'(drop_cnt), CNT_W));
            end
            if (err_event) begin
                err_cnt  <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: three configurations share one input stream and are
// compared every cycle against a behavioural model of the slot rules.
module tb_stream_demux_1xn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_data;
    logic [1:0] i_sel;
    logic [3:0] y_ready;

    // Instance 0: N_OUT=4, backpressure
    logic        a_ready;
    logic [3:0]  a_y_valid;
    logic [31:0] a_y_data;
    logic [15:0] a_drop;
    logic [15:0] a_err;
    logic        a_flag;

    // Instance 1: N_OUT=4, discard, 2-bit counters
    logic        b_ready;
    logic [3:0]  b_y_valid;
    logic [31:0] b_y_data;
    logic [1:0]  b_drop;
    logic [1:0]  b_err;
    logic        b_flag;

    // Instance 2: N_OUT=3, backpressure
    logic        c_ready;
    logic [2:0]  c_y_valid;
    logic [23:0] c_y_data;
    logic [15:0] c_drop;
    logic [15:0] c_err;
    logic        c_flag;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state per instance
    bit       m_valid [3][4];
    bit [7:0] m_data  [3][4];
    int       m_drop  [3];
    int       m_err   [3];
    bit       m_flag  [3];
    int       cfg_n    [3] = '{4, 4, 3};
    int       cfg_dmode[3] = '{0, 1, 0};
    int       cfg_max  [3] = '{65535, 3, 65535};

    always #5 clk = ~clk;

    stream_demux_1xn #(.N_OUT(4), .DATA_W(8), .DROP_MODE(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_sel(i_sel),
        .i_ready(a_ready), .y_valid(a_y_valid), .y_data(a_y_data), .y_ready(y_ready),
        .drop_cnt(a_drop), .err_cnt(a_err), .err_flag(a_flag)
    );

    stream_demux_1xn #(.N_OUT(4), .DATA_W(8), .DROP_MODE(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_sel(i_sel),
        .i_ready(b_ready), .y_valid(b_y_valid), .y_data(b_y_data), .y_ready(y_ready),
        .drop_cnt(b_drop), .err_cnt(b_err), .err_flag(b_flag)
    );

    stream_demux_1xn #(.N_OUT(3), .DATA_W(8), .DROP_MODE(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_sel(i_sel),
        .i_ready(c_ready), .y_valid(c_y_valid), .y_data(c_y_data), .y_ready(y_ready[2:0]),
        .drop_cnt(c_drop), .err_cnt(c_err), .err_flag(c_flag)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Ready rule: nothing in reset, always in discard mode, otherwise target empty or leaving.
    function automatic bit ref_ready(input int d);
        int sel;
        sel = int'(i_sel);
        if (!rst_n) return 1'b0;
        if (cfg_dmode[d] != 0) return 1'b1;
        if (sel >= cfg_n[d]) return 1'b1;
        return !m_valid[d][sel] || y_ready[sel];
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            bit acc;
            bit fr [4];
            int sel;
            sel = int'(i_sel);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    m_valid[d][k] = 1'b0;
                    m_data[d][k]  = 8'h00;
                end
                m_drop[d] = 0;
                m_err[d]  = 0;
                m_flag[d] = 1'b0;
            end else begin
                acc = i_valid && ref_ready(d);
                for (int k = 0; k < 4; k++) fr[k] = !m_valid[d][k] || y_ready[k];
                if (acc && sel >= cfg_n[d]) begin
                    if (m_err[d] < cfg_max[d]) m_err[d]++;
                    m_flag[d] = 1'b1;
                end else if (acc && !fr[sel]) begin
                    if (m_drop[d] < cfg_max[d]) m_drop[d]++;
                end
                for (int k = 0; k < cfg_n[d]; k++) begin
                    if (acc && sel == k && fr[k]) begin
                        m_valid[d][k] = 1'b1;
                        m_data[d][k]  = i_data;
                    end else if (m_valid[d][k] && y_ready[k]) begin
                        m_valid[d][k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_dut(input int d, input logic rdy, input logic [3:0] yv, input logic [31:0] yd,
                               input logic [15:0] dc, input logic [15:0] ec, input logic fl);
        logic [3:0]  ev;
        logic [31:0] ed;
        ev = '0;
        ed = '0;
        for (int k = 0; k < 4; k++) begin
            ev[k]        = m_valid[d][k];
            ed[k*8 +: 8] = m_data[d][k];
        end
        checkOutput($sformatf("dut%0d i_ready", d),  64'(rdy), 64'(ref_ready(d)));
        checkOutput($sformatf("dut%0d y_valid", d),  64'(yv),  64'(ev));
        checkOutput($sformatf("dut%0d y_data", d),   64'(yd),  64'(ed));
        checkOutput($sformatf("dut%0d drop_cnt", d), 64'(dc),  64'(m_drop[d]));
        checkOutput($sformatf("dut%0d err_cnt", d),  64'(ec),  64'(m_err[d]));
        checkOutput($sformatf("dut%0d err_flag", d), 64'(fl),  64'(m_flag[d]));
    endtask

    task automatic compare_all();
        compare_dut(0, a_ready, a_y_valid, a_y_data, a_drop, a_err, a_flag);
        compare_dut(1, b_ready, b_y_valid, b_y_data, {14'b0, b_drop}, {14'b0, b_err}, b_flag);
        compare_dut(2, c_ready, {1'b0, c_y_valid}, {8'h00, c_y_data}, c_drop, c_err, c_flag);
    endtask

    // One clock cycle: drive, compare mid-cycle, advance the model, cross the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] data, input logic [1:0] sel, input logic [3:0] yr);
        i_valid = v;
        i_data  = data;
        i_sel   = sel;
        y_ready = yr;
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_sel   = 2'd0;
        y_ready = 4'h0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'h5A, 2'd0, 4'hF);
        rst_n = 1'b1;

        // Consecutive beats to every channel with all outputs ready
        applyStimulus(1'b1, 8'hA1, 2'd0, 4'hF);
        applyStimulus(1'b1, 8'hA2, 2'd1, 4'hF);
        applyStimulus(1'b1, 8'hA3, 2'd2, 4'hF);
        applyStimulus(1'b1, 8'hA4, 2'd3, 4'hF);
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
        checkOutput("held data after drain", 64'(a_y_data), 64'h00000000A4A3A2A1);

        // Stalled channel 2: second beat waits until the slot drains
        applyStimulus(1'b1, 8'h55, 2'd2, 4'b1011);
        checkOutput("stall ready low", 64'(a_ready), 64'd0);
        applyStimulus(1'b1, 8'h66, 2'd2, 4'b1011);
        applyStimulus(1'b1, 8'h66, 2'd2, 4'b1011);
        applyStimulus(1'b1, 8'h66, 2'd2, 4'b1011);
        checkOutput("stall holds 0x55", 64'(a_y_data[23:16]), 64'h55);
        applyStimulus(1'b1, 8'h66, 2'd2, 4'hF);
        checkOutput("0x66 follows", 64'({a_y_valid[2], a_y_data[23:16]}), 64'h166);
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
        rst_n = 1'b1;

        // Discard mode: stalled channel 1 keeps the first beat, later beats counted
        applyStimulus(1'b1, 8'h11, 2'd1, 4'b1101);
        applyStimulus(1'b1, 8'h12, 2'd1, 4'b1101);
        applyStimulus(1'b1, 8'h13, 2'd1, 4'b1101);
        checkOutput("drop_cnt after 2 drops", 64'(b_drop), 64'd2);
        checkOutput("first beat held", 64'({b_y_valid[1], b_y_data[15:8]}), 64'h111);
        applyStimulus(1'b1, 8'h14, 2'd1, 4'b1101);
        applyStimulus(1'b1, 8'h15, 2'd1, 4'b1101);
        applyStimulus(1'b1, 8'h16, 2'd1, 4'b1101);
        checkOutput("drop_cnt saturates", 64'(b_drop), 64'd3);

        // Out-of-range select on the 3-channel instance
        applyStimulus(1'b1, 8'h99, 2'd3, 4'hF);
        checkOutput("oor ready high", 64'(c_ready), 64'd1);
        checkOutput("oor no valid", 64'(c_y_valid), 64'd0);
        checkOutput("oor err_cnt", 64'(c_err), 64'd1);
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
        checkOutput("err_flag sticky", 64'(c_flag), 64'd1);

        // Reset while slots 0 and 3 are full, then a normal first beat
        applyStimulus(1'b1, 8'hB0, 2'd0, 4'h0);
        applyStimulus(1'b1, 8'hB3, 2'd3, 4'h0);
        checkOutput("slots 0,3 full", 64'(a_y_valid), 64'b1001);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hEE, 2'd1, 4'h0);
        rst_n = 1'b1;
        checkOutput("post-reset y_valid", 64'(a_y_valid), 64'd0);
        checkOutput("post-reset counters", 64'({b_drop, c_err, c_flag}), 64'd0);
        applyStimulus(1'b1, 8'h77, 2'd1, 4'hF);
        checkOutput("post-reset beat", 64'({a_y_valid, a_y_data[15:8]}), 64'h277);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom()), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15) | (($urandom_range(0, 1) != 0) ? 15 : 0)));
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
